// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - decode/execute pipeline register with freeze, flush and operand snooping
module id_ex_stage_reg #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [DW-1:0]    pc_in,
  input  logic [DW-1:0]    val_rn_in,
  input  logic [DW-1:0]    val_rm_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             wb_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm24_in,
  input  logic [3:0]       status_in,
  input  logic             writeBackEn,
  input  logic [3:0]       Dest_wb,
  input  logic [DW-1:0]    Result_WB,
  output logic             valid_out,
  output logic [DW-1:0]    pc_out,
  output logic [DW-1:0]    val_rn_out,
  output logic [DW-1:0]    val_rm_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       exe_cmd_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             wb_en_out,
  output logic             b_out,
  output logic             s_out,
  output logic             imm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm24_out,
  output logic [3:0]       status_out,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] val_rn;
    logic [DW-1:0] val_rm;
    logic [3:0]    src1;
    logic [3:0]    src2;
    logic [3:0]    dest;
    logic [3:0]    exe_cmd;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          wb_en;
    logic          b;
    logic          s;
    logic          imm;
    logic [11:0]   shift_operand;
    logic [23:0]   signed_imm24;
    logic [3:0]    status;
  } entry_t;

  entry_t            entry_in;
  entry_t            entry_d, entry_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              refresh_rn, refresh_rm;

  always_comb begin
    entry_in               = '0;
    entry_in.valid         = valid_in;
    entry_in.pc            = pc_in;
    entry_in.val_rn        = val_rn_in;
    entry_in.val_rm        = val_rm_in;
    entry_in.src1          = src1_in;
    entry_in.src2          = src2_in;
    entry_in.dest          = dest_in;
    entry_in.exe_cmd       = exe_cmd_in;
    entry_in.mem_r_en      = mem_r_en_in;
    entry_in.mem_w_en      = mem_w_en_in;
    entry_in.wb_en         = wb_en_in;
    entry_in.b             = b_in;
    entry_in.s             = s_in;
    entry_in.imm           = imm_in;
    entry_in.shift_operand = shift_operand_in;
    entry_in.signed_imm24  = signed_imm24_in;
    entry_in.status        = status_in;
  end

  // R15 is the PC and never lives in the register file, so it is never snooped.
  assign refresh_rn = writeBackEn && entry_q.valid && (Dest_wb != 4'd15) && (Dest_wb == entry_q.src1);
  assign refresh_rm = writeBackEn && entry_q.valid && (Dest_wb != 4'd15) && (Dest_wb == entry_q.src2);

  always_comb begin
    entry_d = entry_q;
    cnt_d   = cnt_q;
    if (flush) begin
      entry_d = '0;
    end else if (freeze) begin
      if (refresh_rn) entry_d.val_rn = Result_WB;
      if (refresh_rm) entry_d.val_rm = Result_WB;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      entry_d = entry_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
      cnt_q   <= '0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_out         = entry_q.valid;
  assign pc_out            = entry_q.pc;
  assign val_rn_out        = entry_q.val_rn;
  assign val_rm_out        = entry_q.val_rm;
  assign src1_out          = entry_q.src1;
  assign src2_out          = entry_q.src2;
  assign dest_out          = entry_q.dest;
  assign exe_cmd_out       = entry_q.exe_cmd;
  assign mem_r_en_out      = entry_q.mem_r_en;
  assign mem_w_en_out      = entry_q.mem_w_en;
  assign wb_en_out         = entry_q.wb_en;
  assign b_out             = entry_q.b;
  assign s_out             = entry_q.s;
  assign imm_out           = entry_q.imm;
  assign shift_operand_out = entry_q.shift_operand;
  assign signed_imm24_out  = entry_q.signed_imm24;
  assign status_out        = entry_q.status;
  assign stall_cnt         = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;
  localparam int DW = 32;
  localparam int CNT_W = 4;

  logic clk = 1'b0, reset = 1'b0, freeze = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [DW-1:0] pc_in = '0, val_rn_in = '0, val_rm_in = '0, Result_WB = '0;
  logic [3:0] src1_in = '0, src2_in = '0, dest_in = '0, exe_cmd_in = '0, status_in = '0, Dest_wb = '0;
  logic mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, wb_en_in = 1'b0, b_in = 1'b0, s_in = 1'b0, imm_in = 1'b0;
  logic writeBackEn = 1'b0;
  logic [11:0] shift_operand_in = '0;
  logic [23:0] signed_imm24_in = '0;

  logic valid_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out;
  logic [DW-1:0] pc_out, val_rn_out, val_rm_out;
  logic [3:0] src1_out, src2_out, dest_out, exe_cmd_out, status_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0, n_err = 0;

  id_ex_stage_reg #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in), .exe_cmd_in(exe_cmd_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .shift_operand_in(shift_operand_in),
    .signed_imm24_in(signed_imm24_in), .status_in(status_in),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
    .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .src1_out(src1_out), .src2_out(src2_out), .dest_out(dest_out), .exe_cmd_out(exe_cmd_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out),
    .b_out(b_out), .s_out(s_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
    .signed_imm24_out(signed_imm24_out), .status_out(status_out), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference entry: an array of fields indexed by name; the counter is a plain int.
  localparam int F_VALID = 0, F_PC = 1, F_RN = 2, F_RM = 3, F_S1 = 4, F_S2 = 5, F_DEST = 6,
                 F_CMD = 7, F_MR = 8, F_MW = 9, F_WB = 10, F_B = 11, F_S = 12, F_IMM = 13,
                 F_SH = 14, F_I24 = 15, F_ST = 16, NF = 17;
  logic [63:0] exp_f [NF];
  int exp_cnt = 0;

  function automatic void load_model();
    exp_f[F_VALID] = 64'(valid_in);   exp_f[F_PC]  = 64'(pc_in);
    exp_f[F_RN]    = 64'(val_rn_in);  exp_f[F_RM]  = 64'(val_rm_in);
    exp_f[F_S1]    = 64'(src1_in);    exp_f[F_S2]  = 64'(src2_in);
    exp_f[F_DEST]  = 64'(dest_in);    exp_f[F_CMD] = 64'(exe_cmd_in);
    exp_f[F_MR]    = 64'(mem_r_en_in); exp_f[F_MW] = 64'(mem_w_en_in);
    exp_f[F_WB]    = 64'(wb_en_in);   exp_f[F_B]   = 64'(b_in);
    exp_f[F_S]     = 64'(s_in);       exp_f[F_IMM] = 64'(imm_in);
    exp_f[F_SH]    = 64'(shift_operand_in); exp_f[F_I24] = 64'(signed_imm24_in);
    exp_f[F_ST]    = 64'(status_in);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NF; i++) exp_f[i] = '0;
      exp_cnt = 0;
    end else if (flush) begin
      for (int i = 0; i < NF; i++) exp_f[i] = '0;
    end else if (freeze) begin
      if (writeBackEn && exp_f[F_VALID] == 1 && Dest_wb != 15) begin
        if (64'(Dest_wb) == exp_f[F_S1]) exp_f[F_RN] = 64'(Result_WB);
        if (64'(Dest_wb) == exp_f[F_S2]) exp_f[F_RM] = 64'(Result_WB);
      end
      exp_cnt = (exp_cnt + 1 > 15) ? 15 : exp_cnt + 1;
    end else begin
      load_model();
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("valid_out", 64'(valid_out), exp_f[F_VALID]);
    chk("pc_out", 64'(pc_out), exp_f[F_PC]);
    chk("val_rn_out", 64'(val_rn_out), exp_f[F_RN]);
    chk("val_rm_out", 64'(val_rm_out), exp_f[F_RM]);
    chk("src1_out", 64'(src1_out), exp_f[F_S1]);
    chk("src2_out", 64'(src2_out), exp_f[F_S2]);
    chk("dest_out", 64'(dest_out), exp_f[F_DEST]);
    chk("exe_cmd_out", 64'(exe_cmd_out), exp_f[F_CMD]);
    chk("mem_r_en_out", 64'(mem_r_en_out), exp_f[F_MR]);
    chk("mem_w_en_out", 64'(mem_w_en_out), exp_f[F_MW]);
    chk("wb_en_out", 64'(wb_en_out), exp_f[F_WB]);
    chk("b_out", 64'(b_out), exp_f[F_B]);
    chk("s_out", 64'(s_out), exp_f[F_S]);
    chk("imm_out", 64'(imm_out), exp_f[F_IMM]);
    chk("shift_operand_out", 64'(shift_operand_out), exp_f[F_SH]);
    chk("signed_imm24_out", 64'(signed_imm24_out), exp_f[F_I24]);
    chk("status_out", 64'(status_out), exp_f[F_ST]);
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
  end

  // Advance one rising edge and land just after the next per-cycle compare.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                        input logic [5:0] ctl, input logic [3:0] cmd, input logic v);
    pc_in = pc; val_rn_in = rn; val_rm_in = rm;
    src1_in = s1; src2_in = s2; dest_in = d; exe_cmd_in = cmd; valid_in = v;
    {mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in} = ctl;
    shift_operand_in = pc[11:0] ^ 12'hA5C;
    signed_imm24_in = rn[23:0];
    status_in = cmd ^ 4'h9;
  endtask

  task automatic set_wb(input logic en, input logic [3:0] d, input logic [31:0] r);
    writeBackEn = en; Dest_wb = d; Result_WB = r;
  endtask

  logic [31:0] pat_pc [4] = '{32'h0000_0100, 32'hFFFF_FFFC, 32'h8000_0000, 32'h0000_0044};
  logic [5:0]  pat_ctl [4] = '{6'b101010, 6'b010101, 6'b111111, 6'b000000};
  logic [1:0]  pat_mode [4] = '{2'd0, 2'd1, 2'd1, 2'd2};

  initial begin
    // Reset asserted: everything reads 0 before any edge.
    #2;
    chk("reset valid_out", 64'(valid_out), 64'd0);
    chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
    set_in(32'h10, 32'hA5A5A5A5, 32'h0, 4'd1, 4'd0, 4'd3, 6'b001000, 4'd4, 1'b1);
    cyc(2);
    chk("reset pc_out", 64'(pc_out), 64'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    cyc();
    chk("load pc_out", 64'(pc_out), 64'h10);
    chk("load val_rn_out", 64'(val_rn_out), 64'hA5A5A5A5);
    chk("load valid_out", 64'(valid_out), 64'd1);
    chk("load dest_out", 64'(dest_out), 64'd3);

    // Hold with refresh of both operands, then last writer wins, then a miss.
    set_in(32'h20, 32'h1, 32'h2, 4'd2, 4'd2, 4'd7, 6'b011000, 4'd2, 1'b1);
    cyc();
    freeze = 1'b1;
    set_in(32'h99, 32'h99, 32'h99, 4'd9, 4'd9, 4'd9, 6'b111111, 4'd9, 1'b1);
    set_wb(1'b1, 4'd2, 32'hDEADBEEF);
    cyc();
    chk("refresh val_rn_out", 64'(val_rn_out), 64'hDEADBEEF);
    chk("refresh val_rm_out", 64'(val_rm_out), 64'hDEADBEEF);
    chk("refresh pc_out", 64'(pc_out), 64'h20);
    set_wb(1'b1, 4'd2, 32'h12345678);
    cyc();
    chk("last writer val_rn_out", 64'(val_rn_out), 64'h12345678);
    set_wb(1'b1, 4'd5, 32'h55555555);
    cyc();
    chk("miss val_rm_out", 64'(val_rm_out), 64'h12345678);
    chk("hold stall_cnt", 64'(stall_cnt), 64'd3);

    // R15 is never refreshed.
    freeze = 1'b0; set_wb(1'b0, 4'd0, 32'h0);
    set_in(32'h30, 32'h0BAD_F00D, 32'h7, 4'd15, 4'd4, 4'd1, 6'b100000, 4'd1, 1'b1);
    cyc();
    freeze = 1'b1; set_wb(1'b1, 4'd15, 32'hCAFE_CAFE);
    cyc();
    chk("r15 val_rn_out", 64'(val_rn_out), 64'h0BAD_F00D);
    chk("r15 stall_cnt", 64'(stall_cnt), 64'd4);

    // Flush beats freeze and does not count as a stall.
    flush = 1'b1;
    cyc();
    chk("flush valid_out", 64'(valid_out), 64'd0);
    chk("flush wb_en_out", 64'(wb_en_out), 64'd0);
    chk("flush mem_w_en_out", 64'(mem_w_en_out), 64'd0);
    chk("flush stall_cnt", 64'(stall_cnt), 64'd4);

    // A held bubble never snoops, even for index 0.
    flush = 1'b0; set_wb(1'b1, 4'd0, 32'hFFFF_FFFF);
    cyc();
    chk("bubble val_rn_out", 64'(val_rn_out), 64'd0);
    chk("bubble stall_cnt", 64'(stall_cnt), 64'd5);

    // Counter saturates at 15 with CNT_W=4.
    set_wb(1'b0, 4'd0, 32'h0);
    cyc(20);
    chk("sat stall_cnt", 64'(stall_cnt), 64'd15);

    // Mixed directed patterns: 0=load, 1=hold with write-back, 2=flush.
    freeze = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(pat_pc[i], ~pat_pc[i], pat_pc[i] + 32'd3, 4'(i + 1), 4'(i + 2), 4'(i),
             pat_ctl[i], 4'(i * 3), 1'b1);
      freeze = (pat_mode[i] == 2'd1);
      flush  = (pat_mode[i] == 2'd2);
      set_wb(1'b1, 4'(i + 1), pat_pc[i] ^ 32'h0F0F_0F0F);
      cyc();
    end
    freeze = 1'b0; flush = 1'b0; set_wb(1'b0, 4'd0, 32'h0);

    // Async reset between edges while frozen.
    set_in(32'h40, 32'h4444, 32'h8888, 4'd3, 4'd6, 4'd8, 6'b101101, 4'd6, 1'b1);
    cyc();
    freeze = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async valid_out", 64'(valid_out), 64'd0);
    chk("async pc_out", 64'(pc_out), 64'd0);
    chk("async val_rm_out", 64'(val_rm_out), 64'd0);
    chk("async stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk); #1;
    reset = 1'b1; freeze = 1'b0;
    cyc(2);
    chk("post reset pc_out", 64'(pc_out), 64'h40);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Pipeline register between the decode stage and the execute stage of the pipelined ARM core. It captures the decoded control word and the two operands read from the register file, and presents them to the execute stage one cycle later. It supports freeze (hazard stall) and flush (taken branch). While an entry is frozen, it snoops the write-back port so its held operands never go stale. It also keeps a saturating count of freeze cycles for performance debug.

## Interface
Parameters:
- `DW`, 32, datapath width (operands, PC, write-back data)
- `CNT_W`, 16, width of the stall counter

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `freeze`  in  1  hold current entry (hazard stall)
- `flush`  in  1  replace the entry with a bubble (taken branch)
- `valid_in`  in  1  decode slot holds a real instruction
- `pc_in`  in  DW  PC of the decoded instruction
- `val_rn_in`, `val_rm_in`  in  DW  register-file read data for `src1_in` / `src2_in`
- `src1_in`, `src2_in`, `dest_in`  in  4  register indices
- `exe_cmd_in`  in  4  ALU command
- `mem_r_en_in`, `mem_w_en_in`, `wb_en_in`, `b_in`, `s_in`, `imm_in`  in  1  control bits
- `shift_operand_in`  in  12  shifter operand field
- `signed_imm24_in`  in  24  branch offset
- `status_in`  in  4  NZCV flags at decode
- `writeBackEn`, `Dest_wb`, `Result_WB`  in  1/4/DW  write-back port (same signals that drive the register file)
- `*_out`  out  (same widths)  registered copies of every `*_in` above, including `valid_out`
- `stall_cnt`  out  CNT_W  saturating count of cycles with `freeze`=1 and `flush`=0

## Operation
- Three update modes on each rising edge, in priority order:
  - **Flush** (`flush`=1): load a bubble. `flush` beats `freeze`.
  - **Hold** (`freeze`=1, `flush`=0): keep the entry; apply operand refresh.
  - **Load** (otherwise): capture all `*_in` into `*_out`.
- **Bubble:**
  - `valid_out`, `wb_en_out`, `mem_r_en_out`, `mem_w_en_out`, `b_out` and `s_out` are all 0.
  - Every other output is 0 as well.
  - `stall_cnt` is not changed by a bubble.
- **Operand refresh during Hold:**
  - Condition: `writeBackEn`=1, `valid_out`=1, and `Dest_wb` equals `src1_out`.
  - Action: `val_rn_out` <= `Result_WB`.
  - `val_rm_out` is refreshed the same way using `src2_out`.
  - Both operands update in the same cycle if both indices match.
  - Index 15 (PC) never refreshes; the register file holds only R0–R14.
- **Load path:** no refresh. The register file writes on the falling edge, so `val_*_in` sampled at the rising edge already reflect the same-cycle write-back.
- **`stall_cnt`:** increments on every Hold cycle and saturates at all-ones (no wrap). Only reset clears it.

## Timing
- Latency is 1 cycle: inputs present before edge N appear on `*_out` after edge N.
- No combinational path from any input to any output.
- Reset:
  - Effect is immediate on `reset`=0, with no clock required.
  - Every output, including `stall_cnt`, goes to 0.
  - The first Load can occur on the first rising edge with `reset`=1.
- Reset mid-Hold discards the held entry; no refresh survives reset.
- `freeze` held for K cycles means exactly K Hold edges: outputs are stable except for refreshes, and `stall_cnt` rises by K (capped).
- Refresh on edge N is visible on `val_*_out` after edge N. Further write-backs to the same index overwrite it on later Hold edges (last writer wins).

## Test plan
- Reset then Load:
  - Stimulus: `reset`=0, then release; drive `pc_in`=0x10, `val_rn_in`=0xA5A5A5A5, `dest_in`=3, `wb_en_in`=1, `valid_in`=1.
  - Response: all outputs 0 during reset; one edge after release `pc_out`=0x10, `val_rn_out`=0xA5A5A5A5, `valid_out`=1.
- Flush over freeze:
  - Stimulus: valid entry held, then `freeze`=1 and `flush`=1 together.
  - Response: `valid_out`=0, `wb_en_out`=0, `mem_w_en_out`=0, `stall_cnt` unchanged.
- Hold refresh:
  - Stimulus: entry with `src1_out`=2 and `src2_out`=2 held; `writeBackEn`=1, `Dest_wb`=2, `Result_WB`=0xDEADBEEF.
  - Response: `val_rn_out`=`val_rm_out`=0xDEADBEEF; other outputs unchanged.
- No refresh cases:
  - Stimulus: held entry with `src1_out`=15, `Dest_wb`=15; then a held bubble with `src1_out`=0, `Dest_wb`=0.
  - Response: `val_rn_out` unchanged in both cases.
- Counter saturation:
  - Stimulus: `CNT_W`=4, `freeze`=1 for 20 cycles.
  - Response: `stall_cnt` climbs to 15 and stays at 15.
- Async reset mid-Hold:
  - Stimulus: pull `reset`=0 between edges while frozen.
  - Response: all outputs read 0 before the next rising edge.
